// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and the stall/flush controller.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_reg_dest;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_bubble;
    logic             mem_busy;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;

    // Datapath side: supplies hazard/memory status, consumes controls.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_reg_dest, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
               id_ex_flush, mem_wb_bubble, mem_busy, mem_error, stall_count
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_reg_dest, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
               id_ex_flush, mem_wb_bubble, mem_busy, mem_error, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock,
// taken-branch flush, data-memory freeze with timeout, stall counter.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          clock,
    input  logic          reset,
    pipeline_ctrl_if.slave bus
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    logic [1:0]       state, next_state;
    logic [15:0]      wait_cnt, next_wait;
    logic [CNT_W-1:0] stall_cnt;

    logic load_use;
    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}
    logic [5:0] flow;
    logic [5:0] ctl;
    logic       bubble, busy, error;

    // Hazard detection; $0 is never a real producer.
    always_comb begin
        load_use = bus.ex_mem_read && (bus.ex_reg_dest != 5'd0) &&
                   ((bus.ex_reg_dest == bus.id_rs) ||
                    (bus.id_uses_rt && (bus.ex_reg_dest == bus.id_rt)));
    end

    // Flow controls when memory is not holding the pipe: branch beats load-use.
    always_comb begin
        if (bus.ex_branch_taken)
            flow = 6'b1111_11;
        else if (load_use)
            flow = 6'b0011_01;
        else
            flow = 6'b1111_00;
    end

    // Output decode and next-state logic.
    always_comb begin
        ctl        = '0;
        bubble     = 1'b0;
        busy       = 1'b0;
        error      = 1'b0;
        next_state = state;
        next_wait  = wait_cnt;
        if (reset) begin
            ctl    = 6'b0000_11;
            bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        bubble     = 1'b1;
                        next_state = MEM_WAIT;
                        next_wait  = 16'd1;
                    end else begin
                        ctl = flow;
                    end
                end
                MEM_WAIT: begin
                    busy = 1'b1;
                    if (!bus.mem_ready) begin
                        bubble = 1'b1;
                        if (wait_cnt == WAIT_LAST)
                            next_state = ERROR;
                        else
                            next_wait = wait_cnt + 16'd1;
                    end else begin
                        ctl        = flow;
                        next_state = RUN;
                        next_wait  = '0;
                    end
                end
                ERROR: begin
                    bubble = 1'b1;
                    error  = 1'b1;
                end
                default: begin
                    bubble     = 1'b1;
                    next_state = RUN;
                    next_wait  = '0;
                end
            endcase
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt <= '0;
        else if (!ctl[5] && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.pc_en         = ctl[5];
    assign bus.if_id_en      = ctl[4];
    assign bus.id_ex_en      = ctl[3];
    assign bus.ex_mem_en     = ctl[2];
    assign bus.if_id_flush   = ctl[1];
    assign bus.id_ex_flush   = ctl[0];
    assign bus.mem_wb_bubble = bubble;
    assign bus.mem_busy      = busy;
    assign bus.mem_error     = error;
    assign bus.stall_count   = stall_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_ctrl;
    localparam int unsigned CW = 4;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
    //  mem_wb_bubble, mem_busy, mem_error}
    localparam logic [8:0] C_RUN = 9'b1111_00_0_0_0;
    localparam logic [8:0] C_RST = 9'b0000_11_1_0_0;
    localparam logic [8:0] C_FRZ = 9'b0000_00_1_0_0;
    localparam logic [8:0] C_FRW = 9'b0000_00_1_1_0;
    localparam logic [8:0] C_BR  = 9'b1111_11_0_0_0;
    localparam logic [8:0] C_LU  = 9'b0011_01_0_0_0;
    localparam logic [8:0] C_ERR = 9'b0000_00_1_0_1;
    localparam logic [8:0] M_ALL = 9'b1_1111_1111;
    localparam logic [8:0] M_NOB = 9'b1_1111_1101;

    typedef struct {
        string      nm;
        logic [8:0] ctl;
        logic [8:0] mask;
        int         cnt;
    } exp_t;

    logic clock;
    logic reset;
    int   passed;
    int   total;
    exp_t q[$];

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One cycle of stimulus; the expected response is queued for the monitor.
    task automatic cyc(input string nm, input logic rst,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] dest, input logic mrd, input logic br,
                       input logic req, input logic rdy,
                       input logic [8:0] ectl, input logic [8:0] emask, input int ecnt);
        exp_t e;
        @(posedge clock);
        #1;
        reset               = rst;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_uses_rt      = urt;
        bus.ex_reg_dest     = dest;
        bus.ex_mem_read     = mrd;
        bus.ex_branch_taken = br;
        bus.mem_req         = req;
        bus.mem_ready       = rdy;
        e.nm   = nm;
        e.ctl  = ectl;
        e.mask = emask;
        e.cnt  = ecnt;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input int ecnt);
        cyc(nm, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, M_ALL, ecnt);
    endtask

    task automatic rst_cyc(input string nm, input int ecnt);
        cyc(nm, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST, M_ALL, ecnt);
    endtask

    task automatic memc(input string nm, input logic br, input logic req, input logic rdy,
                        input logic [8:0] ectl, input logic [8:0] emask, input int ecnt);
        cyc(nm, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, br, req, rdy, ectl, emask, ecnt);
    endtask

    // Monitor: the controller presents a response every cycle; check mid-cycle.
    initial begin
        logic [8:0] act;
        exp_t       e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                       bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble,
                       bus.mem_busy, bus.mem_error};
                total++;
                if ((act & e.mask) === (e.ctl & e.mask))
                    passed++;
                else
                    $display("FAIL %s ctl: got %b want %b (mask %b)", e.nm, act, e.ctl, e.mask);
                if (e.cnt >= 0) begin
                    total++;
                    if (bus.stall_count === CW'(e.cnt))
                        passed++;
                    else
                        $display("FAIL %s stall_count: got %0d want %0d", e.nm, bus.stall_count, e.cnt);
                end
            end
        end
    end

    initial begin
        passed              = 0;
        total               = 0;
        reset               = 1'b1;
        bus.id_rs           = '0;
        bus.id_rt           = '0;
        bus.id_uses_rt      = 1'b0;
        bus.ex_reg_dest     = '0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;

        // Reset and idle
        rst_cyc("rst0", -1);
        rst_cyc("rst1", 0);
        idle("idle0", 0);
        idle("idle1", 0);

        // Load-use interlock and its non-hazard variants
        cyc("lu_rs", 1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, M_ALL, 0);
        idle("after_lu", 1);
        cyc("lu_r0", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, M_ALL, 1);
        cyc("rt_unused", 1'b0, 5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, M_ALL, 1);
        cyc("lu_rt", 1'b0, 5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, M_ALL, 1);
        cyc("no_load", 1'b0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, M_ALL, 2);

        // Branch wins over a same-cycle load-use
        cyc("br_lu", 1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, M_ALL, 2);
        idle("after_br", 2);

        // Memory wait of 3 cycles with a branch held, released on the 4th
        rst_cyc("rst_mw", -1);
        idle("mw_idle", 0);
        memc("mw_c1", 1'b0, 1'b1, 1'b0, C_FRZ, M_ALL, 0);
        memc("mw_c2", 1'b1, 1'b1, 1'b0, C_FRW, M_ALL, 1);
        memc("mw_c3", 1'b1, 1'b1, 1'b0, C_FRW, M_ALL, 2);
        memc("mw_rel", 1'b1, 1'b1, 1'b1, C_BR, M_NOB, 3);
        idle("mw_after", 3);
        memc("req_rdy", 1'b0, 1'b1, 1'b1, C_RUN, M_ALL, 3);
        idle("req_rdy_after", 3);

        // Timeout into sticky ERROR
        memc("to_c1", 1'b0, 1'b1, 1'b0, C_FRZ, M_ALL, 3);
        memc("to_c2", 1'b0, 1'b1, 1'b0, C_FRW, M_ALL, 4);
        memc("to_c3", 1'b0, 1'b1, 1'b0, C_FRW, M_ALL, 5);
        memc("to_c4", 1'b0, 1'b1, 1'b0, C_FRW, M_ALL, 6);
        memc("err_rdy", 1'b0, 1'b0, 1'b1, C_ERR, M_ALL, 7);
        memc("err_br", 1'b1, 1'b1, 1'b1, C_ERR, M_ALL, 8);
        rst_cyc("err_rst", 9);
        idle("err_clr", 0);

        // Saturation of stall_count
        for (int i = 0; i < 22; i++)
            memc("sat", 1'b0, 1'b1, 1'b0,
                 (i == 0) ? C_FRZ : ((i < 4) ? C_FRW : C_ERR), M_ALL, (i < 15) ? i : 15);

        // Reset in the middle of a wait
        rst_cyc("sat_rst", 15);
        idle("sat_clr", 0);
        memc("mr_c1", 1'b0, 1'b1, 1'b0, C_FRZ, M_ALL, 0);
        memc("mr_c2", 1'b0, 1'b1, 1'b0, C_FRW, M_ALL, 1);
        cyc("mr_rst", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_RST, M_ALL, 2);
        idle("mr_run", 0);
        idle("mr_run2", 0);

        for (int k = 0; k < 4 && q.size() > 0; k++)
            @(posedge clock);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX.
- Handles taken-branch flushes resolved in EX.
- Freezes the pipeline while the data memory is busy, and declares a fatal error if memory never answers.
- Drives the enable and flush/bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Keeps a saturating count of stall cycles for performance reading.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before entering ERROR (legal range 2..65535)
CNT_W, 16, width of stall_count

Ports:
clock  in  1  rising-edge clock for all state
reset  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_reg_dest  in  5  destination register of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EX/MEM register enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
mem_wb_bubble  out  1  MEM/WB captures a bubble (reg_dest forced to 0)
mem_busy  out  1  high in MEM_WAIT
mem_error  out  1  sticky; high in ERROR
stall_count  out  CNT_W  saturating count of cycles with pc_en=0, excluding reset

Behaviour:
- All control outputs are combinational from the current state and the current inputs, so there is zero-cycle latency. Only the state, wait_cnt and stall_count are registered.
- Reset (sampled at a clock edge while reset=1):
  - state=RUN, wait_cnt=0, stall_count=0.
  - While reset is high: all enables 0, if_id_flush=id_ex_flush=mem_wb_bubble=1, mem_busy=0, mem_error=0.
  - Reset overrides every state, including ERROR and a wait in progress.
- States: RUN, MEM_WAIT, ERROR.
- Memory stall (mstall) = (state==RUN && mem_req && !mem_ready) || state==MEM_WAIT && !mem_ready.
- RUN priority, highest first:
  1. mstall: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, all flushes 0. Next state MEM_WAIT, wait_cnt<=1.
  2. ex_branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1. A load-use hazard in the same cycle is ignored because the ID instruction is wrong-path.
  3. Load-use, defined as ex_mem_read && ex_reg_dest!=0 && (ex_reg_dest==id_rs || (id_uses_rt && ex_reg_dest==id_rt)): pc_en=if_id_en=0, id_ex_en=ex_mem_en=1, id_ex_flush=1.
  4. Otherwise: all enables 1, all flushes/bubbles 0.
- MEM_WAIT:
  - mem_busy=1. Outputs are as case 1 while !mem_ready.
  - mem_ready=1: release. Outputs are evaluated as in RUN cases 2–4, with the mem_req term ignored for this cycle. Next state RUN, wait_cnt<=0.
  - !mem_ready and wait_cnt==MEM_TIMEOUT-1: next state ERROR.
  - Else wait_cnt<=wait_cnt+1.
  - ex_branch_taken or a hazard asserted during MEM_WAIT has no effect until release, because EX is frozen and holds it.
- ERROR: all enables 0, mem_wb_bubble=1, flushes 0, mem_error=1, mem_busy=0. Remains until reset; mem_ready is ignored.
- stall_count:
  - Increments on each non-reset edge where pc_en=0.
  - Holds at 2^CNT_W-1 and never wraps.
  - Also counts cycles spent in ERROR.
- Register $0 never creates a hazard.
- mem_req with mem_ready=1 in the same RUN cycle causes no stall.

Test Plan:
1. Reset, then idle inputs → enables all 1, flushes 0, stall_count=0, state RUN.
2. Load-use: ex_mem_read=1, ex_reg_dest=8, id_rs=8 for 1 cycle → pc_en=if_id_en=0, id_ex_flush=1, stall_count=1. Repeat with ex_reg_dest=0 → no stall. Repeat with id_rt=8 and id_uses_rt=0 → no stall.
3. Branch plus load-use in the same cycle → if_id_flush=id_ex_flush=1, pc_en=1, stall_count unchanged.
4. Memory wait: mem_req=1, mem_ready low for 3 cycles then high → 3 cycles of freeze with mem_wb_bubble=1 (mem_busy high on cycles 2–3), release on cycle 4, stall_count=3. A branch held during the wait flushes exactly on the release cycle.
5. Timeout with MEM_TIMEOUT=4: mem_ready never asserted → ERROR entered after the 4th stalled cycle, mem_error=1 sticky. A later mem_ready=1 leaves enables 0. Reset returns to RUN with mem_error=0.
6. Saturation with CNT_W=4: force 20 stall cycles → stall_count reads 15. Reset asserted mid MEM_WAIT → RUN and counters 0 on the next edge.
